// File: rtl/dyn_reconf_bank.sv
// DRP register bank for the PLL/MMCM model: DRP access with programmable DRDY latency,
// plus combinational decode of the stored ClkReg words into divide/duty/phase values.
//
//  state  | meaning
//  IDLE   | waiting for DEN; latches address, write flag and data
//  WAIT   | latency countdown; register write or DO load on the edge leaving it
//  ACK    | DRDY (and CFG_UPDATE for mapped writes) high for one cycle
module dyn_reconf_bank #(
    parameter int N_CLKOUT     = 6,
    parameter int DRDY_LATENCY = 3,
    parameter int VCO_W        = 33,
    parameter int PHASE_W      = 40
) (
    input  logic                          DCLK,
    input  logic                          RST_N,
    input  logic [VCO_W-1:0]              vco_period_1000,
    input  logic [6:0]                    DADDR,
    input  logic                          DEN,
    input  logic                          DWE,
    input  logic [15:0]                   DI,
    output logic [15:0]                   DO,
    output logic                          DRDY,
    output logic                          DBUSY,
    output logic                          CFG_UPDATE,
    output logic [8*N_CLKOUT-1:0]         CLKOUT_DIVIDE,
    output logic [10*N_CLKOUT-1:0]        CLKOUT_DUTY_1000,
    output logic [PHASE_W*N_CLKOUT-1:0]   CLKOUT_PHASE,
    output logic [7:0]                    CLKFBOUT_MULT,
    output logic [PHASE_W-1:0]            CLKFBOUT_PHASE,
    output logic [7:0]                    DIVCLK_DIVIDE
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    localparam logic [15:0] REG1_RST = 16'h0041;
    localparam logic [15:0] REG2_RST = 16'h0040;
    localparam logic [15:0] DIV_RST  = 16'h1041;
    localparam logic [3:0]  CNT_LOAD = 4'(DRDY_LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [6:0]  addr_q;
    logic        we_q;
    logic [15:0] di_q;
    logic [15:0] clk_reg1 [N_CLKOUT];
    logic [15:0] clk_reg2 [N_CLKOUT];
    logic [15:0] fb_reg1, fb_reg2, div_reg;
    logic [15:0] rd_data;
    logic        mapped;
    logic        commit;

    // HIGH/LOW counts encode 64 as zero
    function automatic logic [6:0] f_cnt(input logic [5:0] f);
        return (f == 6'd0) ? 7'd64 : {1'b0, f};
    endfunction

    function automatic logic [7:0] f_div(input logic [5:0] h, input logic [5:0] l, input logic nc);
        return nc ? 8'd1 : 8'(f_cnt(h)) + 8'(f_cnt(l));
    endfunction

    function automatic logic [9:0] f_duty(input logic [5:0] h, input logic [5:0] l,
                                          input logic e, input logic nc);
        if (nc)
            return 10'd500;
        return 10'((({10'd0, f_cnt(h), 1'b0} + 18'(e)) * 18'd500) / 18'(f_div(h, l, 1'b0)));
    endfunction

    // vco*(8*dly+mux)/8 split so that no intermediate exceeds PHASE_W bits
    function automatic logic [PHASE_W-1:0] f_phase(input logic [VCO_W-1:0] vco,
                                                   input logic [5:0] dly, input logic [2:0] mux);
        return PHASE_W'(vco) * PHASE_W'(dly) + ((PHASE_W'(vco) * PHASE_W'(mux)) >> 3);
    endfunction

    always_comb begin
        rd_data = 16'h0000;
        mapped  = 1'b0;
        for (int k = 0; k < N_CLKOUT; k++) begin
            if (addr_q == 7'(8 + 2 * k)) begin
                rd_data = clk_reg1[k];
                mapped  = 1'b1;
            end
            if (addr_q == 7'(9 + 2 * k)) begin
                rd_data = clk_reg2[k];
                mapped  = 1'b1;
            end
        end
        if (addr_q == 7'h14) begin
            rd_data = fb_reg1;
            mapped  = 1'b1;
        end
        if (addr_q == 7'h15) begin
            rd_data = fb_reg2;
            mapped  = 1'b1;
        end
        if (addr_q == 7'h16) begin
            rd_data = div_reg;
            mapped  = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        commit     = 1'b0;
        DRDY       = 1'b0;
        DBUSY      = 1'b0;
        CFG_UPDATE = 1'b0;
        case (state)
            ST_IDLE: begin
                if (DEN)
                    state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                DBUSY = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = ST_ACK;
                    commit    = 1'b1;
                end
            end
            ST_ACK: begin
                DBUSY      = 1'b1;
                DRDY       = 1'b1;
                CFG_UPDATE = we_q & mapped;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            addr_q  <= 7'd0;
            we_q    <= 1'b0;
            di_q    <= 16'h0000;
            DO      <= 16'h0000;
            fb_reg1 <= REG1_RST;
            fb_reg2 <= REG2_RST;
            div_reg <= DIV_RST;
            for (int k = 0; k < N_CLKOUT; k++) begin
                clk_reg1[k] <= REG1_RST;
                clk_reg2[k] <= REG2_RST;
            end
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && DEN) begin
                addr_q <= DADDR;
                we_q   <= DWE;
                di_q   <= DI;
                cnt    <= CNT_LOAD;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !we_q)
                DO <= rd_data;
            if (commit && we_q) begin
                for (int k = 0; k < N_CLKOUT; k++) begin
                    if (addr_q == 7'(8 + 2 * k))
                        clk_reg1[k] <= di_q;
                    if (addr_q == 7'(9 + 2 * k))
                        clk_reg2[k] <= di_q;
                end
                if (addr_q == 7'h14)
                    fb_reg1 <= di_q;
                if (addr_q == 7'h15)
                    fb_reg2 <= di_q;
                if (addr_q == 7'h16)
                    div_reg <= di_q;
            end
        end
    end

    for (genvar k = 0; k < N_CLKOUT; k++) begin : g_ch
        assign CLKOUT_DIVIDE[8*k +: 8] =
            f_div(clk_reg1[k][11:6], clk_reg1[k][5:0], clk_reg2[k][6]);
        assign CLKOUT_DUTY_1000[10*k +: 10] =
            f_duty(clk_reg1[k][11:6], clk_reg1[k][5:0], clk_reg2[k][7], clk_reg2[k][6]);
        assign CLKOUT_PHASE[PHASE_W*k +: PHASE_W] =
            f_phase(vco_period_1000, clk_reg2[k][5:0], clk_reg1[k][15:13]);
    end

    assign CLKFBOUT_MULT  = f_div(fb_reg1[11:6], fb_reg1[5:0], fb_reg2[6]);
    assign CLKFBOUT_PHASE = f_phase(vco_period_1000, fb_reg2[5:0], fb_reg1[15:13]);
    assign DIVCLK_DIVIDE  = f_div(div_reg[11:6], div_reg[5:0], div_reg[12]);

endmodule

// File: tb/tb_dyn_reconf_bank.sv
// Directed bench for dyn_reconf_bank: one instance at DRDY latency 3, one at latency 1.
module tb_dyn_reconf_bank;

    localparam int NC = 6;
    localparam int PW = 40;

    logic        dclk = 1'b0;
    logic        rst0, rst1;
    logic [32:0] vco;
    logic [6:0]  daddr;
    logic        dwe, den0, den1;
    logic [15:0] di_s;

    logic [15:0]      do0, do1;
    logic             drdy0, drdy1, busy0, busy1, cfg0, cfg1;
    logic [8*NC-1:0]  div0, div1;
    logic [10*NC-1:0] duty0, duty1;
    logic [PW*NC-1:0] ph0, ph1;
    logic [7:0]       mult0, mult1, dvc0, dvc1;
    logic [PW-1:0]    fbph0, fbph1;

    int n_chk = 0;
    int n_err = 0;
    int cfg_cnt0 = 0, cfg_cnt1 = 0, drdy_cnt0 = 0, drdy_cnt1 = 0;
    logic [15:0] do_obs;

    always #5 dclk = ~dclk;

    dyn_reconf_bank #(.N_CLKOUT(NC), .DRDY_LATENCY(3), .VCO_W(33), .PHASE_W(PW)) u_dut0 (
        .DCLK(dclk), .RST_N(rst0), .vco_period_1000(vco), .DADDR(daddr), .DEN(den0),
        .DWE(dwe), .DI(di_s), .DO(do0), .DRDY(drdy0), .DBUSY(busy0), .CFG_UPDATE(cfg0),
        .CLKOUT_DIVIDE(div0), .CLKOUT_DUTY_1000(duty0), .CLKOUT_PHASE(ph0),
        .CLKFBOUT_MULT(mult0), .CLKFBOUT_PHASE(fbph0), .DIVCLK_DIVIDE(dvc0));

    dyn_reconf_bank #(.N_CLKOUT(NC), .DRDY_LATENCY(1), .VCO_W(33), .PHASE_W(PW)) u_dut1 (
        .DCLK(dclk), .RST_N(rst1), .vco_period_1000(vco), .DADDR(daddr), .DEN(den1),
        .DWE(dwe), .DI(di_s), .DO(do1), .DRDY(drdy1), .DBUSY(busy1), .CFG_UPDATE(cfg1),
        .CLKOUT_DIVIDE(div1), .CLKOUT_DUTY_1000(duty1), .CLKOUT_PHASE(ph1),
        .CLKFBOUT_MULT(mult1), .CLKFBOUT_PHASE(fbph1), .DIVCLK_DIVIDE(dvc1));

    // Pulse counters sampled mid-cycle
    always @(negedge dclk) begin
        if (cfg0)  cfg_cnt0++;
        if (cfg1)  cfg_cnt1++;
        if (drdy0) drdy_cnt0++;
        if (drdy1) drdy_cnt1++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One DRP transaction; checks DBUSY after the sampling edge and the DRDY latency
    task automatic drp(input int inst, input logic [6:0] addr, input logic we,
                       input logic [15:0] wd, input int lat, input string tag);
        int  n;
        logic seen;
        @(negedge dclk);
        daddr = addr;
        dwe   = we;
        di_s  = wd;
        if (inst == 0) den0 = 1'b1;
        else           den1 = 1'b1;
        @(posedge dclk);
        #1;
        den0 = 1'b0;
        den1 = 1'b0;
        chk({tag, " busy"}, (inst == 0) ? busy0 : busy1, 1'b1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            if (n > 0 || lat > 0) begin
                @(posedge dclk);
                #1;
            end
            n++;
            if ((inst == 0) ? drdy0 : drdy1) begin
                seen   = 1'b1;
                do_obs = (inst == 0) ? do0 : do1;
            end
        end
        chk({tag, " latency"}, n, lat);
        @(posedge dclk);
        #1;
    endtask

    int c0, d0;

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        den0 = 1'b0; den1 = 1'b0;
        dwe = 1'b0; daddr = 7'd0; di_s = 16'h0000;
        vco = 33'd32000;
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        rst0 = 1'b1; rst1 = 1'b1;
        @(posedge dclk);
        #1;

        // Reset state
        chk("rst drdy", drdy0, 1'b0);
        chk("rst busy", busy0, 1'b0);
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("rst div%0d", k), div0[8*k +: 8], 8'd1);
            chk($sformatf("rst duty%0d", k), duty0[10*k +: 10], 10'd500);
            chk($sformatf("rst phase%0d", k), ph0[PW*k +: PW], 40'd0);
        end
        chk("rst mult", mult0, 8'd1);
        chk("rst fbphase", fbph0, 40'd0);
        chk("rst divclk", dvc0, 8'd1);
        drp(0, 7'h16, 1'b0, 16'h0000, 3, "rd 16");
        chk("rd 16 do", do_obs, 16'h1041);

        // Channel 0 counting: clear NO_COUNT, then H=6 L=3 MUX=3
        drp(0, 7'h09, 1'b1, 16'h0000, 3, "wr 09 clr");
        chk("ch0 div H1L1", div0[7:0], 8'd2);
        chk("ch0 duty H1L1", duty0[9:0], 10'd500);
        c0 = cfg_cnt0;
        drp(0, 7'h08, 1'b1, 16'b011_0_000110_000011, 3, "wr 08");
        repeat (3) @(posedge dclk);
        #1;
        chk("wr 08 cfg pulses", cfg_cnt0 - c0, 1);
        chk("ch0 div 9", div0[7:0], 8'd9);
        chk("ch0 duty 666", duty0[9:0], 10'd666);
        chk("ch0 phase 12000", ph0[PW-1:0], 40'd12000);

        // NO_COUNT with DELAY=3: phase = 32000*27/8
        drp(0, 7'h09, 1'b1, 16'h0043, 3, "wr 09");
        chk("ch0 div nocount", div0[7:0], 8'd1);
        chk("ch0 duty nocount", duty0[9:0], 10'd500);
        chk("ch0 phase 108000", ph0[PW-1:0], 40'd108000);
        drp(0, 7'h09, 1'b0, 16'h0000, 3, "rd 09");
        chk("rd 09 do", do_obs, 16'h0043);

        // H=L=64 with EDGE
        drp(0, 7'h0A, 1'b1, 16'h0000, 3, "wr 0A");
        drp(0, 7'h0B, 1'b1, 16'h0080, 3, "wr 0B");
        chk("ch1 div 128", div0[15:8], 8'd128);
        chk("ch1 duty 503", duty0[19:10], 10'd503);
        chk("ch1 phase 0", ph0[2*PW-1:PW], 40'd0);
        drp(0, 7'h08, 1'b0, 16'h0000, 3, "rd 08");
        chk("rd 08 do", do_obs, 16'h6183);

        // Unmapped accesses
        c0 = cfg_cnt0;
        d0 = drdy_cnt0;
        drp(0, 7'h7F, 1'b0, 16'h0000, 3, "rd 7F");
        chk("rd 7F do", do_obs, 16'h0000);
        drp(0, 7'h7F, 1'b1, 16'hFFFF, 3, "wr 7F");
        drp(0, 7'h07, 1'b1, 16'hFFFF, 3, "wr 07");
        repeat (2) @(posedge dclk);
        #1;
        chk("unmapped cfg pulses", cfg_cnt0 - c0, 0);
        chk("unmapped drdy pulses", drdy_cnt0 - d0, 3);
        chk("wr 07 no effect ch0", div0[7:0], 8'd1);

        // DEN held through WAIT and ACK: only the first request is served
        d0 = drdy_cnt0;
        @(negedge dclk);
        daddr = 7'h16; dwe = 1'b0; den0 = 1'b1;
        @(posedge dclk);
        #1;
        daddr = 7'h09;
        repeat (4) @(posedge dclk);
        #1;
        den0 = 1'b0;
        repeat (6) @(posedge dclk);
        #1;
        chk("den busy drdy pulses", drdy_cnt0 - d0, 1);
        chk("den busy do", do0, 16'h1041);
        chk("den busy idle", busy0, 1'b0);

        // Feedback and DIVCLK; DO holds across writes
        drp(0, 7'h14, 1'b1, 16'h0104, 3, "wr 14");
        drp(0, 7'h15, 1'b1, 16'h0001, 3, "wr 15");
        chk("do held", do0, 16'h1041);
        chk("fb mult 8", mult0, 8'd8);
        chk("fb phase", fbph0, 40'd32000);
        drp(0, 7'h16, 1'b1, 16'h0082, 3, "wr 16");
        chk("divclk 4", dvc0, 8'd4);

        // Latency 1 instance
        c0 = cfg_cnt1;
        drp(1, 7'h09, 1'b1, 16'h0000, 1, "l1 wr 09");
        drp(1, 7'h08, 1'b1, 16'b011_0_000110_000011, 1, "l1 wr 08");
        chk("l1 cfg pulses", cfg_cnt1 - c0, 2);
        chk("l1 div 9", div1[7:0], 8'd9);
        chk("l1 duty 666", duty1[9:0], 10'd666);
        chk("l1 phase 12000", ph1[PW-1:0], 40'd12000);

        // Reset in the middle of WAIT
        d0 = drdy_cnt0;
        @(negedge dclk);
        daddr = 7'h0A; dwe = 1'b1; di_s = 16'h0145; den0 = 1'b1;
        @(posedge dclk);
        #1;
        den0 = 1'b0;
        @(posedge dclk);
        #1;
        rst0 = 1'b0;
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        rst0 = 1'b1;
        repeat (5) @(posedge dclk);
        #1;
        chk("abort drdy pulses", drdy_cnt0 - d0, 0);
        chk("abort busy", busy0, 1'b0);
        chk("abort do", do0, 16'h0000);
        chk("abort ch1 div", div0[15:8], 8'd1);
        chk("abort ch1 duty", duty0[19:10], 10'd500);
        chk("abort mult", mult0, 8'd1);
        chk("abort fbphase", fbph0, 40'd0);
        chk("abort divclk", dvc0, 8'd1);
        drp(0, 7'h0A, 1'b0, 16'h0000, 3, "abort rd 0A");
        chk("abort rd 0A do", do_obs, 16'h0041);
        drp(0, 7'h0B, 1'b0, 16'h0000, 3, "abort rd 0B");
        chk("abort rd 0B do", do_obs, 16'h0040);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
